// File: rtl/itof.sv
// itof: pipelined signed 32-bit integer to IEEE-754 single-precision converter.
// Three register stages (sign/magnitude, normalise, round/pack) under one
// shared enable. Rounding is round-to-nearest, ties-to-even. Zero gives +0.
//
// Ports:
//   clk        sole clock, all state on posedge
//   rst        synchronous reset, active-high
//   x          signed two's-complement operand
//   in_valid   x is valid this cycle
//   in_ready   converter accepts x this cycle (equals the pipeline enable)
//   y          single-precision result {sign, exp[7:0], man[22:0]}
//   out_valid  y is valid
//   out_ready  consumer takes y this cycle
`timescale 1ns/1ps
module itof (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  // The whole pipe advances together; it only stalls when the output
  // register holds a result nobody has taken yet.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage 1: sign, magnitude, zero flag
  logic        v1, s1, z1;
  logic [31:0] a1;

  // Stage 2: normalised magnitude (the implicit leading one is dropped)
  logic        v2, s2, z2;
  logic [4:0]  lz2;
  logic [30:0] n2;

  // Leading-zero count of the stage-1 magnitude. Scanning upward lets the
  // highest set bit win; a zero magnitude leaves lz at 0, which is harmless
  // because the zero flag overrides the result later.
  logic [4:0]  lz1;
  logic [31:0] n1;
  always_comb begin
    lz1 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (a1[i]) lz1 = 5'(31 - i);
    end
    n1 = a1 << lz1;
  end

  // Rounding of the normalised value: 23 kept bits, then guard and sticky.
  logic [22:0] m;
  logic        grd, sticky, rnd;
  logic [23:0] mr;
  logic [7:0]  ex;
  logic [22:0] man;
  always_comb begin
    m      = n2[30:8];
    grd    = n2[7];
    sticky = |n2[6:0];
    rnd    = grd & (sticky | m[0]);
    mr     = {1'b0, m} + {23'd0, rnd};
    // A carry out of the mantissa means the value rounded up to the next
    // power of two: the fraction becomes zero and the exponent bumps by one.
    ex     = 8'd158 - {3'd0, lz2} + {7'd0, mr[23]};
    man    = mr[23] ? 23'd0 : mr[22:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      z1        <= 1'b0;
      a1        <= 32'd0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      z2        <= 1'b0;
      lz2       <= 5'd0;
      n2        <= 31'd0;
      out_valid <= 1'b0;
      y         <= 32'd0;
    end else if (en) begin
      v1        <= in_valid;
      s1        <= x[31];
      a1        <= x[31] ? (~x + 32'd1) : x;
      z1        <= (x == 32'd0);

      v2        <= v1;
      s2        <= s1;
      z2        <= z1;
      lz2       <= lz1;
      n2        <= n1[30:0];

      out_valid <= v2;
      y         <= z2 ? 32'd0 : {s2, ex, man};
    end
  end

endmodule

// File: tb/tb_itof.sv
// tb_itof: randomized self-checking bench for itof. A scoreboard queue holds
// the expected float bit pattern of every accepted operand, computed by an
// arithmetic reference model, and is matched in order against each
// retired result.
`timescale 1ns/1ps
module tb_itof;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;

  itof dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] expv;
    int          cyc;
  } entry_t;

  entry_t      sb[$];
  int          compareCount = 0;
  int          failCount = 0;
  int          cycle = 0;
  bit          checkLatency = 0;
  logic        sInReady, sOutValid;
  logic [31:0] sY;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compareCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  // Reference model: integer magnitude divided down to 24 significant bits,
  // remainder compared against one half for ties-to-even.
  function automatic logic [31:0] refConv(input logic [31:0] xi);
    longint mag, q, r, half;
    int     e, sh;
    if (xi == 32'd0) return 32'd0;
    mag = xi[31] ? (64'h1_0000_0000 - {32'd0, xi}) : {32'd0, xi};
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      r    = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {xi[31], 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] randX();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom >> $urandom_range(0, 31);
      2: v = -($urandom >> $urandom_range(0, 31));
      default: v = (({$urandom_range(1, 32'hFFFF), 8'h80}) << $urandom_range(0, 8)) ^ {31'd0, 1'($urandom_range(0, 1))};
    endcase
    return v;
  endfunction

  // One cycle: drive inputs after the falling edge, let them settle, then
  // record what the coming rising edge will transfer in each direction.
  task automatic applyStimulus(input logic r, input logic vin, input logic [31:0] xin,
                               input logic ordy, input logic [31:0] expv, output logic accepted);
    entry_t e;
    @(negedge clk);
    rst = r;
    in_valid = vin;
    x = xin;
    out_ready = ordy;
    #1;
    cycle++;
    sInReady = in_ready;
    sOutValid = out_valid;
    sY = y;
    accepted = 1'b0;
    if (r) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("y", y, e.expv);
          if (checkLatency) checkOutput("latency", 32'(cycle - e.cyc), 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        sb.push_back('{expv: expv, cyc: cycle});
      end
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, acc);
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] dirX [8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                            32'd16777217, 32'd16777219, 32'd16777218};
  logic [31:0] dirY [8] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'hCF000000,
                            32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4B800001};

  initial begin
    logic        acc;
    logic [31:0] xi, curX;
    logic [31:0] ops [4];
    int          p, n, cnt;
    logic        vin, ordy;

    rst = 1'b1;
    in_valid = 1'b0;
    x = 32'd0;
    out_ready = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, acc);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, acc);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, acc);
    checkOutput("rst_out_valid", {31'd0, sOutValid}, 32'd0);
    checkOutput("rst_y", sY, 32'd0);
    checkOutput("rst_in_ready", {31'd0, sInReady}, 32'd1);

    // Directed values and rounding ties
    checkLatency = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, dirX[i], 1'b1, dirY[i], acc);
      checkOutput("dir_accept", {31'd0, acc}, 32'd1);
    end
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 5000; i++) begin
      xi = randX();
      applyStimulus(1'b0, 1'b1, xi, 1'b1, refConv(xi), acc);
      checkOutput("stream_accept", {31'd0, acc}, 32'd1);
      if (i >= 3) checkOutput("stream_valid", {31'd0, sOutValid}, 32'd1);
    end
    drain();
    checkLatency = 0;

    // Back-pressure: fill with out_ready low, then release
    for (int i = 0; i < 4; i++) ops[i] = randX();
    p = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1, ops[p], 1'b0, refConv(ops[p]), acc);
      if (acc) p++;
      if (c >= 3) begin
        checkOutput("bp_in_ready", {31'd0, sInReady}, 32'd0);
        checkOutput("bp_hold_valid", {31'd0, sOutValid}, 32'd1);
        checkOutput("bp_hold_y", sY, refConv(ops[0]));
      end
    end
    checkOutput("bp_fill", 32'(p), 32'd3);
    for (int c = 0; c < 4; c++) begin
      xi = ops[(p < 4) ? p : 3];
      applyStimulus(1'b0, (p < 4), xi, 1'b1, refConv(xi), acc);
      if (acc) p++;
      checkOutput("bp_release_valid", {31'd0, sOutValid}, 32'd1);
    end
    checkOutput("bp_all_in", 32'(p), 32'd4);
    drain();

    // Reset with three operands in flight
    for (int c = 0; c < 3; c++) begin
      xi = randX();
      applyStimulus(1'b0, 1'b1, xi, 1'b1, refConv(xi), acc);
    end
    xi = randX();
    applyStimulus(1'b1, 1'b1, xi, 1'b0, refConv(xi), acc);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, acc);
    checkOutput("midrst_out_valid", {31'd0, sOutValid}, 32'd0);
    checkOutput("midrst_y", sY, 32'd0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, acc);
      checkOutput("midrst_no_stale", {31'd0, sOutValid}, 32'd0);
    end

    // Random valid/ready toggling
    n = 0;
    cnt = 0;
    curX = randX();
    while (n < 5000 && cnt < 40000) begin
      vin  = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, vin, curX, ordy, refConv(curX), acc);
      if (acc) begin
        n++;
        curX = randX();
      end
      cnt++;
    end
    checkOutput("rand_count", 32'(n), 32'd5000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
